// File: rtl/pipeline_exec_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline: gates PC and pipeline
// register enables, drains the pipe after HALT and counts enabled cycles.
module pipeline_exec_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_SZ       = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_halt_D,
  input  logic              i_stall_D,
  output logic              o_pc_en,
  output logic              o_pipe_en,
  output logic              o_flush_IF_ID,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state,
  output logic [CNT_SZ-1:0] o_cycle_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        drain_q, drain_d;
  logic [CNT_SZ-1:0] cnt_q, cnt_d;
  logic              halt_acc;

  // A stalled HALT is not taken; it is retried while still decoded in ID.
  assign halt_acc = i_halt_D & ~i_stall_D;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    o_pc_en       = 1'b0;
    o_pipe_en     = 1'b0;
    o_flush_IF_ID = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (state_q)
      RUN, STEP: begin
        o_pc_en   = 1'b1;
        o_pipe_en = 1'b1;
        o_busy    = 1'b1;
      end
      DRAIN: begin
        o_pipe_en     = 1'b1;
        o_flush_IF_ID = 1'b1;
        o_busy        = 1'b1;
      end
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    if (o_pipe_en && cnt_q != {CNT_SZ{1'b1}})
      cnt_d = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (i_start)     state_d = RUN;
        else if (i_step) state_d = STEP;
      end
      RUN: begin
        if (halt_acc) begin
          state_d = DRAIN;
          drain_d = 4'(DRAIN_CYCLES);
        end
      end
      STEP: begin
        if (halt_acc) begin
          state_d = DRAIN;
          drain_d = 4'(DRAIN_CYCLES);
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        drain_d = drain_q - 4'd1;
        // the <= guard keeps a corrupted zero count from sticking in DRAIN
        if (drain_q <= 4'd1) begin
          state_d = DONE;
          drain_d = '0;
        end
      end
      DONE:    ;
      default: state_d = IDLE;
    endcase
    if (i_clear) begin
      state_d = IDLE;
      drain_d = '0;
      cnt_d   = '0;
    end
  end

  assign o_state     = state_q;
  assign o_cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Bench for pipeline_exec_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_pipeline_exec_ctrl;

  localparam int DR = 3;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_clear = 1'b0, i_start = 1'b0, i_step = 1'b0;
  logic        i_halt_D = 1'b0, i_stall_D = 1'b0;
  logic        pc_en, pipe_en, flush, busy, done;
  logic [2:0]  state;
  logic [31:0] cnt;
  logic        pc_en4, pipe_en4, flush4, busy4, done4;
  logic [2:0]  state4;
  logic [3:0]  cnt4;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  pipeline_exec_ctrl #(.DRAIN_CYCLES(DR), .CNT_SZ(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_start(i_start),
    .i_step(i_step), .i_halt_D(i_halt_D), .i_stall_D(i_stall_D),
    .o_pc_en(pc_en), .o_pipe_en(pipe_en), .o_flush_IF_ID(flush),
    .o_busy(busy), .o_done(done), .o_state(state), .o_cycle_cnt(cnt));

  pipeline_exec_ctrl #(.DRAIN_CYCLES(DR), .CNT_SZ(4)) dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_start(i_start),
    .i_step(i_step), .i_halt_D(i_halt_D), .i_stall_D(i_stall_D),
    .o_pc_en(pc_en4), .o_pipe_en(pipe_en4), .o_flush_IF_ID(flush4),
    .o_busy(busy4), .o_done(done4), .o_state(state4), .o_cycle_cnt(cnt4));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // expected {pc_en, pipe_en, flush, busy, done} for each mode
  function automatic logic [4:0] flags_of(input int st);
    case (st)
      1, 2:    return 5'b11010;
      3:       return 5'b01110;
      4:       return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic check_all(input string tag, input int st, input longint c);
    chk({tag, ".state"}, state, st);
    chk({tag, ".flags"}, {pc_en, pipe_en, flush, busy, done}, flags_of(st));
    chk({tag, ".cnt"}, cnt, c);
    chk({tag, ".cnt4"}, cnt4, (c > 15) ? 15 : c);
  endtask

  // drive {clear,start,step,halt,stall} in the low phase, sample 1ns after edge
  task automatic cyc(input logic [4:0] in);
    @(negedge i_clk);
    {i_clear, i_start, i_step, i_halt_D, i_stall_D} = in;
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] in;
    int         st;
    int         cnt;
  } vec_t;
  vec_t tv[$];

  function automatic void add(input logic [4:0] in, input int st, input int c);
    vec_t v;
    v.in = in; v.st = st; v.cnt = c;
    tv.push_back(v);
  endfunction

  // reference model: mode + remaining drain cycles + saturating count
  int     m_mode = 0;
  int     m_rem = 0;
  longint m_cnt = 0;

  function automatic void model_edge(input logic [4:0] in);
    logic c, s, st, h, sl;
    {c, s, st, h, sl} = in;
    if (c) begin
      m_mode = 0; m_rem = 0; m_cnt = 0;
      return;
    end
    if (m_mode inside {1, 2, 3} && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (m_mode == 0) m_mode = s ? 1 : (st ? 2 : 0);
    else if (m_mode inside {1, 2} && h && !sl) begin
      m_mode = 3; m_rem = DR;
    end else if (m_mode == 2) m_mode = 0;
    else if (m_mode == 3) begin
      m_rem--;
      if (m_rem == 0) m_mode = 4;
    end
    else if (m_mode > 4) m_mode = 0;
  endfunction

  initial begin
    // clear, start, step, halt, stall
    add(5'b01000, 1, 0);
    add(5'b00000, 1, 1); add(5'b00000, 1, 2); add(5'b00000, 1, 3);
    add(5'b00000, 1, 4);
    add(5'b00010, 3, 5);
    add(5'b00000, 3, 6); add(5'b00000, 3, 7); add(5'b00000, 4, 8);
    add(5'b01000, 4, 8); add(5'b00100, 4, 8); add(5'b00010, 4, 8);
    add(5'b10000, 0, 0);
    // start+step together -> RUN; stalled HALT held for two cycles
    add(5'b01100, 1, 0);
    add(5'b00011, 1, 1); add(5'b00011, 1, 2);
    add(5'b00010, 3, 3);
    add(5'b00000, 3, 4); add(5'b00000, 3, 5); add(5'b00000, 4, 6);
    add(5'b10000, 0, 0);
    // three single steps spaced four cycles apart
    for (int k = 0; k < 3; k++) begin
      add(5'b00100, 2, k);
      add(5'b00000, 0, k + 1); add(5'b00000, 0, k + 1); add(5'b00000, 0, k + 1);
    end
    // step with HALT drains continuously
    add(5'b00100, 2, 3);
    add(5'b00010, 3, 4);
    add(5'b00000, 3, 5); add(5'b00000, 3, 6); add(5'b00000, 4, 7);
    add(5'b10000, 0, 0);
    // clear coincident with HALT in RUN goes to IDLE, not DRAIN
    add(5'b01000, 1, 0); add(5'b00000, 1, 1);
    add(5'b10010, 0, 0); add(5'b00000, 0, 0);

    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset", 0, 0);
    @(negedge i_clk);
    i_reset = 1'b0;

    foreach (tv[i]) begin
      cyc(tv[i].in);
      check_all($sformatf("vec%0d", i), tv[i].st, tv[i].cnt);
    end

    // 20 run cycles: 4-bit counter saturates at 15
    cyc(5'b01000);
    repeat (20) cyc(5'b00000);
    chk("sat.cnt4", cnt4, 15);
    chk("sat.cnt", cnt, 20);
    cyc(5'b00000);
    chk("sat.hold", cnt4, 15);
    cyc(5'b10000);
    check_all("sat.clear", 0, 0);

    // async reset mid-DRAIN takes effect before the next edge
    cyc(5'b01000);
    cyc(5'b00010);
    cyc(5'b00000);
    check_all("drain", 3, 2);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("arst.state", state, 0);
    chk("arst.flags", {pc_en, pipe_en, flush, busy, done}, 0);
    chk("arst.cnt", cnt, 0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] in;
      in[4] = ($urandom_range(0, 49) == 0);
      in[3] = ($urandom_range(0, 7) == 0);
      in[2] = ($urandom_range(0, 7) == 0);
      in[1] = ($urandom_range(0, 5) == 0);
      in[0] = ($urandom_range(0, 2) == 0);
      cyc(in);
      model_edge(in);
      check_all($sformatf("rnd%0d", n), m_mode, m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
- Run/step/halt sequencer for the 5-stage MIPS pipeline.
- Gates PC and pipeline-register enables in continuous or single-step mode.
- Detects HALT decoded in ID (main control unit halt flag), stops fetch, drains EX/MEM/WB, then parks in DONE.
- Counts executed pipeline cycles for the debug unit.

Parameters:
- DRAIN_CYCLES, 3, cycles pipeline stays enabled after HALT accepted (EX, MEM, WB); legal range 1..15
- CNT_SZ, 32, width of cycle counter

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_clear  in  1  synchronous return to IDLE and clear counter; highest priority
- i_start  in  1  pulse: begin/resume continuous run
- i_step  in  1  pulse: execute exactly one pipeline cycle
- i_halt_D  in  1  HALT decoded in ID (from main control unit)
- i_stall_D  in  1  hazard-unit stall of IF/ID
- o_pc_en  out  1  PC write enable
- o_pipe_en  out  1  enable for IF/ID, ID/EX, EX/MEM, MEM/WB registers
- o_flush_IF_ID  out  1  load bubble into IF/ID
- o_busy  out  1  high in RUN, STEP, DRAIN
- o_done  out  1  high in DONE (level)
- o_state  out  3  current state encoding
- o_cycle_cnt  out  CNT_SZ  count of cycles with o_pipe_en=1

Behaviour:
- States/encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4; others decode to IDLE on next edge.
- Outputs are Moore, decoded from registered state; drain counter and cycle counter registered.
- Reset: state IDLE, drain counter 0, o_cycle_cnt 0; all 1-bit outputs 0, o_state 0.
- IDLE: all enables 0. i_start -> RUN; else i_step -> STEP; i_start wins if both high. Cycle counter held (IDLE doubles as pause).
- RUN: o_pc_en=1, o_pipe_en=1. HALT accepted when i_halt_D=1 and i_stall_D=0 -> DRAIN, drain counter loaded DRAIN_CYCLES. i_start/i_step ignored.
- STEP: one cycle with o_pc_en=1, o_pipe_en=1; next state IDLE, unless HALT accepted that cycle -> DRAIN.
- DRAIN: o_pc_en=0, o_pipe_en=1, o_flush_IF_ID=1. Drain counter decrements each cycle; at counter==1 -> DONE. Exactly DRAIN_CYCLES cycles in DRAIN. Drain runs continuously even if entered from STEP. i_halt_D, i_stall_D, i_start, i_step ignored.
- DONE: all enables 0, o_done=1. Only i_clear (or reset) leaves DONE.
- Latency: command sampled at edge k -> enables high in cycle after edge k.
- i_clear in any state -> IDLE, o_cycle_cnt 0, drain counter 0 at next edge; overrides same-cycle start/step/halt.
- o_cycle_cnt increments on every edge where o_pipe_en=1, including stalled cycles and DRAIN. Saturates at 2^CNT_SZ-1, no wrap.
- HALT with i_stall_D=1 is not accepted; accepted on first unstalled cycle still showing i_halt_D.
- Reset asserted mid-RUN/DRAIN: immediate asynchronous return to reset values.

Test Plan:
- Reset, then i_start pulse; i_halt_D=1 for 1 cycle at 5th RUN cycle -> DRAIN 3 cycles with o_pc_en=0, o_flush_IF_ID=1; then DONE, o_done=1, o_cycle_cnt=8.
- Three i_step pulses spaced 4 cycles apart from IDLE -> o_pipe_en high for exactly 3 single cycles; o_cycle_cnt=3; state returns to 0 after each.
- i_halt_D=1 with i_stall_D=1 for 2 cycles, then stall released -> DRAIN entered only after the unstalled cycle; counter includes the 2 stalled cycles.
- i_start and i_step same cycle -> RUN. In DONE, i_start/i_step pulses -> no change; i_clear -> IDLE, o_cycle_cnt=0.
- CNT_SZ=4, run 20 cycles without halt -> o_cycle_cnt saturates at 15.
- Reset asserted asynchronously mid-DRAIN -> all outputs 0 before next clock edge; i_clear in RUN coincident with i_halt_D -> IDLE, not DRAIN.
